// File: rtl/flags_cond_unit.sv
// Architectural ALU flag register, pending flag-writer tracker and x86 condition evaluator.
// Latency: flag writeback visible next cycle; condition response registered, 1 cycle after acceptance.
// Backpressure: issue_stall holds decode when the tracker is full; cc_req_ready drops while writers are pending.
// Optional FLAGS_BYPASS_EN: accept a request in the cycle of the last pending writeback, evaluated on merged flags.
module flags_cond_unit #(
    parameter int PEND_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flag_wr_issue,
    output logic       issue_stall,
    input  logic       ex_flags_valid,
    input  logic [5:0] ex_flags,
    input  logic [5:0] ex_flags_mask,
    input  logic       cc_req_valid,
    input  logic [3:0] cc_code,
    output logic       cc_req_ready,
    output logic       cc_resp_valid,
    output logic       cc_taken,
    output logic [5:0] flags_out,
    output logic       err_underflow
);

    localparam int OF_B = 5;
    localparam int SF_B = 4;
    localparam int ZF_B = 3;
    localparam int PF_B = 1;
    localparam int CF_B = 0;

    logic [5:0]       r_flags;
    logic [CNT_W-1:0] r_pend_cnt;
    logic             r_resp_vld;
    logic             r_taken;
    logic             r_err;

    logic [5:0] w_merged;
    logic [5:0] w_eval_flags;
    logic       w_issue_acc;
    logic       w_cnt_zero;
    logic       w_req_acc;
    logic       w_underflow;

    // Odd codes invert the even one below them, so only the base predicate is decoded.
    function automatic logic f_eval(input logic [3:0] code, input logic [5:0] f);
        logic base;
        base = 1'b0;
        unique case (code[3:1])
            3'd0: base = f[OF_B];
            3'd1: base = f[CF_B];
            3'd2: base = f[ZF_B];
            3'd3: base = f[CF_B] | f[ZF_B];
            3'd4: base = f[SF_B];
            3'd5: base = f[PF_B];
            3'd6: base = f[SF_B] ^ f[OF_B];
            3'd7: base = f[ZF_B] | (f[SF_B] ^ f[OF_B]);
            default: base = 1'b0;
        endcase
        return base ^ code[0];
    endfunction

    assign w_merged    = (r_flags & ~ex_flags_mask) | (ex_flags & ex_flags_mask);
    assign w_cnt_zero  = (r_pend_cnt == '0);
    assign issue_stall = (r_pend_cnt == CNT_W'(PEND_DEPTH));
    assign w_issue_acc = flag_wr_issue & ~issue_stall;
    assign w_underflow = ex_flags_valid & w_cnt_zero & ~w_issue_acc;

`ifdef FLAGS_BYPASS_EN
    // The last outstanding writer is retiring now; its result is forwarded into the evaluation.
    assign cc_req_ready = w_cnt_zero |
                          ((r_pend_cnt == CNT_W'(1)) & ex_flags_valid & ~w_issue_acc);
    assign w_eval_flags = ex_flags_valid ? w_merged : r_flags;
`else
    assign cc_req_ready = w_cnt_zero;
    assign w_eval_flags = r_flags;
`endif

    // The request is ordered ahead of a same-cycle issue: readiness uses the pre-issue count.
    assign w_req_acc = cc_req_valid & cc_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (ex_flags_valid) begin
            r_flags <= w_merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_cnt <= '0;
        end else if (w_issue_acc && !ex_flags_valid) begin
            r_pend_cnt <= r_pend_cnt + CNT_W'(1);
        end else if (!w_issue_acc && ex_flags_valid && !w_cnt_zero) begin
            r_pend_cnt <= r_pend_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_underflow) begin
            r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_vld <= 1'b0;
            r_taken    <= 1'b0;
        end else begin
            r_resp_vld <= w_req_acc;
            if (w_req_acc) begin
                r_taken <= f_eval(cc_code, w_eval_flags);
            end
        end
    end

    assign cc_resp_valid = r_resp_vld;
    assign cc_taken      = r_taken;
    assign flags_out     = r_flags;
    assign err_underflow = r_err;

endmodule

// File: tb/tb_flags_cond_unit.sv
// Directed table-driven bench for flags_cond_unit; expected values hand-derived from flag semantics.
module tb_flags_cond_unit;

`ifdef FLAGS_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       flag_wr_issue;
    logic       issue_stall;
    logic       ex_flags_valid;
    logic [5:0] ex_flags;
    logic [5:0] ex_flags_mask;
    logic       cc_req_valid;
    logic [3:0] cc_code;
    logic       cc_req_ready;
    logic       cc_resp_valid;
    logic       cc_taken;
    logic [5:0] flags_out;
    logic       err_underflow;

    int n_cmp = 0;
    int n_err = 0;

    flags_cond_unit #(.PEND_DEPTH(4), .CNT_W(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flag_wr_issue (flag_wr_issue),
        .issue_stall   (issue_stall),
        .ex_flags_valid(ex_flags_valid),
        .ex_flags      (ex_flags),
        .ex_flags_mask (ex_flags_mask),
        .cc_req_valid  (cc_req_valid),
        .cc_code       (cc_code),
        .cc_req_ready  (cc_req_ready),
        .cc_resp_valid (cc_resp_valid),
        .cc_taken      (cc_taken),
        .flags_out     (flags_out),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iss;
        logic       exv;
        logic [5:0] exf;
        logic [5:0] exm;
        logic       ccv;
        logic [3:0] cc;
        logic       rdy;
        logic       st;
        logic       rsp;
        logic       tk;
        logic [5:0] fl;
        logic       er;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic iss, input logic exv, input logic [5:0] exf,
                                input logic [5:0] exm, input logic ccv, input logic [3:0] cc,
                                input logic rdy, input logic st, input logic rsp, input logic tk,
                                input logic [5:0] fl, input logic er);
        vec_t v;
        v.iss = iss; v.exv = exv; v.exf = exf; v.exm = exm; v.ccv = ccv; v.cc = cc;
        v.rdy = rdy; v.st = st; v.rsp = rsp; v.tk = tk; v.fl = fl; v.er = er;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [5:0] act, input logic [5:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        flag_wr_issue  = v.iss;
        ex_flags_valid = v.exv;
        ex_flags       = v.exf;
        ex_flags_mask  = v.exm;
        cc_req_valid   = v.ccv;
        cc_code        = v.cc;
    endtask

    // Drive at negedge, check combinational outputs before the edge, registered ones just after.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        drive(v);
        #1;
        chk("cc_req_ready", idx, {5'b0, cc_req_ready}, {5'b0, v.rdy});
        chk("issue_stall",  idx, {5'b0, issue_stall},  {5'b0, v.st});
        @(posedge clk);
        #1;
        chk("cc_resp_valid", idx, {5'b0, cc_resp_valid}, {5'b0, v.rsp});
        chk("cc_taken",      idx, {5'b0, cc_taken},      {5'b0, v.tk});
        chk("flags_out",     idx, flags_out,             v.fl);
        chk("err_underflow", idx, {5'b0, err_underflow}, {5'b0, v.er});
    endtask

    task automatic chk_reset_state(input int idx);
        chk("rst_resp_valid", idx, {5'b0, cc_resp_valid}, 6'h0);
        chk("rst_taken",      idx, {5'b0, cc_taken},      6'h0);
        chk("rst_flags",      idx, flags_out,             6'h0);
        chk("rst_err",        idx, {5'b0, err_underflow}, 6'h0);
        chk("rst_stall",      idx, {5'b0, issue_stall},   6'h0);
        chk("rst_ready",      idx, {5'b0, cc_req_ready},  6'h1);
    endtask

    initial begin
        //             iss exv exf    exm    ccv cc     rdy  st   rsp   tk   fl     er
        // basic evaluation from reset
        tbl.push_back(mk(0, 0, 6'h00, 6'h00, 1, 4'h4,  1,   0,   1,    0,   6'h00, 0));
        tbl.push_back(mk(0, 0, 6'h00, 6'h00, 1, 4'h5,  1,   0,   1,    1,   6'h00, 0));
        tbl.push_back(mk(0, 0, 6'h00, 6'h00, 0, 4'h0,  1,   0,   0,    1,   6'h00, 0));
        // full write then masked merge
        tbl.push_back(mk(1, 0, 6'h00, 6'h00, 0, 4'h0,  1,   0,   0,    1,   6'h00, 0));
        tbl.push_back(mk(0, 1, 6'h3F, 6'h3F, 0, 4'h0,  BYP, 0,   0,    1,   6'h3F, 0));
        tbl.push_back(mk(1, 0, 6'h00, 6'h00, 0, 4'h0,  1,   0,   0,    1,   6'h3F, 0));
        tbl.push_back(mk(0, 1, 6'h00, 6'h3E, 0, 4'h0,  BYP, 0,   0,    1,   6'h01, 0));
        tbl.push_back(mk(0, 0, 6'h00, 6'h00, 1, 4'h2,  1,   0,   1,    1,   6'h01, 0));
        tbl.push_back(mk(0, 0, 6'h00, 6'h00, 1, 4'h6,  1,   0,   1,    1,   6'h01, 0));
        tbl.push_back(mk(0, 0, 6'h00, 6'h00, 1, 4'h7,  1,   0,   1,    0,   6'h01, 0));
        tbl.push_back(mk(0, 0, 6'h00, 6'h00, 1, 4'h1,  1,   0,   1,    1,   6'h01, 0));
        tbl.push_back(mk(0, 0, 6'h00, 6'h00, 1, 4'hA,  1,   0,   1,    0,   6'h01, 0));
        tbl.push_back(mk(0, 0, 6'h00, 6'h00, 1, 4'hB,  1,   0,   1,    1,   6'h01, 0));
        // pending tracker: request ordered ahead of issue, fill, stall, simultaneous ops
        tbl.push_back(mk(1, 0, 6'h00, 6'h00, 1, 4'h4,  1,   0,   1,    0,   6'h01, 0));
        tbl.push_back(mk(1, 0, 6'h00, 6'h00, 1, 4'h5,  0,   0,   0,    0,   6'h01, 0));
        tbl.push_back(mk(1, 0, 6'h00, 6'h00, 0, 4'h0,  0,   0,   0,    0,   6'h01, 0));
        tbl.push_back(mk(1, 0, 6'h00, 6'h00, 0, 4'h0,  0,   0,   0,    0,   6'h01, 0));
        tbl.push_back(mk(1, 0, 6'h00, 6'h00, 0, 4'h0,  0,   1,   0,    0,   6'h01, 0));
        tbl.push_back(mk(0, 0, 6'h00, 6'h00, 0, 4'h0,  0,   1,   0,    0,   6'h01, 0));
        tbl.push_back(mk(1, 1, 6'h00, 6'h00, 0, 4'h0,  0,   1,   0,    0,   6'h01, 0));
        tbl.push_back(mk(1, 1, 6'h00, 6'h00, 0, 4'h0,  0,   0,   0,    0,   6'h01, 0));
        tbl.push_back(mk(0, 0, 6'h00, 6'h00, 0, 4'h0,  0,   0,   0,    0,   6'h01, 0));
        tbl.push_back(mk(1, 0, 6'h00, 6'h00, 0, 4'h0,  0,   0,   0,    0,   6'h01, 0));
        tbl.push_back(mk(0, 1, 6'h00, 6'h00, 0, 4'h0,  0,   1,   0,    0,   6'h01, 0));
        tbl.push_back(mk(0, 1, 6'h00, 6'h00, 0, 4'h0,  0,   0,   0,    0,   6'h01, 0));
        tbl.push_back(mk(0, 1, 6'h00, 6'h00, 0, 4'h0,  0,   0,   0,    0,   6'h01, 0));
        tbl.push_back(mk(0, 0, 6'h00, 6'h00, 0, 4'h0,  0,   0,   0,    0,   6'h01, 0));
        // request waiting on the last writer (accepted in the writeback cycle only with bypass)
        tbl.push_back(mk(0, 0, 6'h00, 6'h00, 1, 4'h4,  0,   0,   0,    0,   6'h01, 0));
        tbl.push_back(mk(0, 1, 6'h08, 6'h3F, 1, 4'h4,  BYP, 0,   BYP,  BYP, 6'h08, 0));
        tbl.push_back(mk(0, 0, 6'h00, 6'h00, ~BYP, 4'h4, 1, 0,   ~BYP, 1,   6'h08, 0));
        // signed conditions
        tbl.push_back(mk(1, 0, 6'h00, 6'h00, 0, 4'h0,  1,   0,   0,    1,   6'h08, 0));
        tbl.push_back(mk(0, 1, 6'h10, 6'h3F, 0, 4'h0,  BYP, 0,   0,    1,   6'h10, 0));
        tbl.push_back(mk(0, 0, 6'h00, 6'h00, 1, 4'hC,  1,   0,   1,    1,   6'h10, 0));
        tbl.push_back(mk(0, 0, 6'h00, 6'h00, 1, 4'hD,  1,   0,   1,    0,   6'h10, 0));
        tbl.push_back(mk(0, 0, 6'h00, 6'h00, 1, 4'hE,  1,   0,   1,    1,   6'h10, 0));
        tbl.push_back(mk(0, 0, 6'h00, 6'h00, 1, 4'hF,  1,   0,   1,    0,   6'h10, 0));
        tbl.push_back(mk(1, 0, 6'h00, 6'h00, 0, 4'h0,  1,   0,   0,    0,   6'h10, 0));
        tbl.push_back(mk(0, 1, 6'h30, 6'h3F, 0, 4'h0,  BYP, 0,   0,    0,   6'h30, 0));
        tbl.push_back(mk(0, 0, 6'h00, 6'h00, 1, 4'hC,  1,   0,   1,    0,   6'h30, 0));
        tbl.push_back(mk(0, 0, 6'h00, 6'h00, 1, 4'hF,  1,   0,   1,    1,   6'h30, 0));
        tbl.push_back(mk(0, 0, 6'h00, 6'h00, 1, 4'h8,  1,   0,   1,    1,   6'h30, 0));
        tbl.push_back(mk(0, 0, 6'h00, 6'h00, 1, 4'h9,  1,   0,   1,    0,   6'h30, 0));
        // underflow: flags still written, error sticky
        tbl.push_back(mk(0, 1, 6'h04, 6'h04, 0, 4'h0,  1,   0,   0,    0,   6'h34, 1));
        tbl.push_back(mk(0, 0, 6'h00, 6'h00, 0, 4'h0,  1,   0,   0,    0,   6'h34, 1));
        tbl.push_back(mk(1, 0, 6'h00, 6'h00, 1, 4'h3,  1,   0,   1,    1,   6'h34, 1));
        tbl.push_back(mk(0, 1, 6'h00, 6'h00, 0, 4'h0,  BYP, 0,   0,    1,   6'h34, 1));
        tbl.push_back(mk(1, 0, 6'h00, 6'h00, 1, 4'h5,  1,   0,   1,    1,   6'h34, 1));

        rst_n = 1'b0;
        drive(mk(0, 0, 6'h00, 6'h00, 0, 4'h0, 0, 0, 0, 0, 6'h00, 0));
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state(-1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Async reset while a response is being presented and a writer is pending.
        #2;
        drive(mk(0, 0, 6'h00, 6'h00, 0, 4'h0, 0, 0, 0, 0, 6'h00, 0));
        rst_n = 1'b0;
        #1;
        chk_reset_state(100);
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(0, 0, 6'h00, 6'h00, 0, 4'h0, 1, 0, 0, 0, 6'h00, 0), 101);
        apply(mk(0, 0, 6'h00, 6'h00, 1, 4'h5, 1, 0, 1, 1, 6'h00, 0), 102);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
